// File: rtl/frame_scan_ctrl_pkg.sv
// rtl/frame_scan_ctrl_pkg.sv - shared state encoding, colour codes and defaults for frame_scan_ctrl
package frame_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] CLR_NONE  = 2'd0;
    localparam logic [1:0] CLR_RED   = 2'd1;
    localparam logic [1:0] CLR_GREEN = 2'd2;
    localparam logic [1:0] CLR_BLUE  = 2'd3;

    localparam int         DEF_IMG_W = 160;
    localparam int         DEF_IMG_H = 120;
    localparam logic [3:0] DEF_CH_TH = 4'h8;

    localparam int          CNT_W   = 15;
    localparam logic [14:0] CNT_MAX = 15'h7FFF;
    localparam int          BX_W    = 8;
    localparam int          BY_W    = 7;

    // Increment that sticks at the top of the counter range
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 15'd1;
    endfunction

endpackage

// File: rtl/frame_scan_ctrl_pixel_classify.sv
// rtl/frame_scan_ctrl_pixel_classify.sv - combinational dominant-channel pixel classifier
module pixel_classify
    import frame_scan_ctrl_pkg::*;
#(
    parameter int         DW    = 12,
    parameter logic [3:0] CH_TH = DEF_CH_TH
) (
    input  logic [DW-1:0] i_pix,
    output logic [1:0]    o_cls
);

    localparam int CW = DW / 3;

    logic [CW-1:0] w_r;
    logic [CW-1:0] w_g;
    logic [CW-1:0] w_b;
    logic [CW-1:0] w_th;

    assign w_r  = i_pix[3*CW-1:2*CW];
    assign w_g  = i_pix[2*CW-1:CW];
    assign w_b  = i_pix[CW-1:0];
    assign w_th = CW'(CH_TH);

    // A channel wins only if strictly above both others and at least the threshold
    always_comb begin
        o_cls = CLR_NONE;
        if (w_r > w_g && w_r > w_b && w_r >= w_th) begin
            o_cls = CLR_RED;
        end else if (w_g > w_r && w_g > w_b && w_g >= w_th) begin
            o_cls = CLR_GREEN;
        end else if (w_b > w_r && w_b > w_g && w_b >= w_th) begin
            o_cls = CLR_BLUE;
        end
    end

endmodule

// File: rtl/frame_scan_ctrl.sv
// rtl/frame_scan_ctrl.sv - frame colour scanner; optional red bounding box with FRAME_SCAN_BBOX_EN
module frame_scan_ctrl
    import frame_scan_ctrl_pkg::*;
#(
    parameter int          AW      = 15,
    parameter int          DW      = 12,
    parameter int          IMG_W   = DEF_IMG_W,
    parameter int          IMG_H   = DEF_IMG_H,
    parameter logic [3:0]  CH_TH   = DEF_CH_TH,
    parameter logic [14:0] MIN_CNT = 15'd500
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    output logic [AW-1:0]    proc_addr,
    input  logic [DW-1:0]    proc_data,
    output logic             busy,
    output logic             done,
    output logic [1:0]       color,
    output logic [CNT_W-1:0] red_cnt,
    output logic [CNT_W-1:0] green_cnt,
    output logic [CNT_W-1:0] blue_cnt
`ifdef FRAME_SCAN_BBOX_EN
    ,
    output logic [BX_W-1:0]  bbox_xmin,
    output logic [BX_W-1:0]  bbox_xmax,
    output logic [BY_W-1:0]  bbox_ymin,
    output logic [BY_W-1:0]  bbox_ymax
`endif
);

    localparam int          NPIX      = IMG_W * IMG_H;
    localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);

    state_t            r_state;
    state_t            w_next;
    logic [AW-1:0]     r_addr;
    logic              w_last;
    logic              w_enter_scan;
    logic              w_publish;
    logic [1:0]        w_cls;
    logic [CNT_W-1:0]  r_wr;
    logic [CNT_W-1:0]  r_wg;
    logic [CNT_W-1:0]  r_wb;
    logic [CNT_W-1:0]  r_red_cnt;
    logic [CNT_W-1:0]  r_green_cnt;
    logic [CNT_W-1:0]  r_blue_cnt;
    logic [1:0]        r_color;
    logic [1:0]        w_best_cls;
    logic [CNT_W-1:0]  w_best_cnt;

    assign w_last       = (r_addr == LAST_ADDR);
    assign w_enter_scan = (r_state == ST_IDLE) && (w_next == ST_SCAN);
    assign w_publish    = (r_state == ST_DRAIN) && !abort;

    pixel_classify #(
        .DW    (DW),
        .CH_TH (CH_TH)
    ) u_classify (
        .i_pix (proc_data),
        .o_cls (w_cls)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and status outputs; abort wins over start in IDLE and cancels SCAN/DRAIN
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !abort) w_next = ST_SCAN;
            end
            ST_SCAN: begin
                busy = 1'b1;
                if (abort)       w_next = ST_IDLE;
                else if (w_last) w_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy   = 1'b1;
                w_next = abort ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Address register: counts only while staying in SCAN, otherwise parked at 0
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr <= '0;
        end else if (r_state == ST_SCAN && w_next == ST_SCAN) begin
            r_addr <= r_addr + 1'b1;
        end else begin
            r_addr <= '0;
        end
    end

    assign proc_addr = r_addr;

    // Working class counters: the pixel on the bus belongs to the address presented this cycle
    always_ff @(posedge clk) begin
        if (reset || w_enter_scan) begin
            r_wr <= '0;
            r_wg <= '0;
            r_wb <= '0;
        end else if (r_state == ST_SCAN) begin
            case (w_cls)
                CLR_RED:   r_wr <= sat_inc(r_wr);
                CLR_GREEN: r_wg <= sat_inc(r_wg);
                CLR_BLUE:  r_wb <= sat_inc(r_wb);
                default:   ;
            endcase
        end
    end

    // Winning class with red > green > blue priority on ties
    always_comb begin
        w_best_cls = CLR_RED;
        w_best_cnt = r_wr;
        if (r_wg > w_best_cnt) begin
            w_best_cls = CLR_GREEN;
            w_best_cnt = r_wg;
        end
        if (r_wb > w_best_cnt) begin
            w_best_cls = CLR_BLUE;
            w_best_cnt = r_wb;
        end
    end

    // Published results change only when a scan completes through DRAIN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_red_cnt   <= '0;
            r_green_cnt <= '0;
            r_blue_cnt  <= '0;
            r_color     <= CLR_NONE;
        end else if (w_publish) begin
            r_red_cnt   <= r_wr;
            r_green_cnt <= r_wg;
            r_blue_cnt  <= r_wb;
            r_color     <= (w_best_cnt < MIN_CNT) ? CLR_NONE : w_best_cls;
        end
    end

    assign red_cnt   = r_red_cnt;
    assign green_cnt = r_green_cnt;
    assign blue_cnt  = r_blue_cnt;
    assign color     = r_color;

`ifdef FRAME_SCAN_BBOX_EN
    localparam logic [BX_W-1:0] X_LAST = BX_W'(IMG_W - 1);

    logic [BX_W-1:0] r_x;
    logic [BY_W-1:0] r_y;
    logic [BX_W-1:0] r_wxmin;
    logic [BX_W-1:0] r_wxmax;
    logic [BY_W-1:0] r_wymin;
    logic [BY_W-1:0] r_wymax;
    logic [BX_W-1:0] r_xmin;
    logic [BX_W-1:0] r_xmax;
    logic [BY_W-1:0] r_ymin;
    logic [BY_W-1:0] r_ymax;

    // Raster coordinates shadow the address so no divider is needed
    always_ff @(posedge clk) begin
        if (reset || w_enter_scan) begin
            r_x <= '0;
            r_y <= '0;
        end else if (r_state == ST_SCAN) begin
            if (r_x == X_LAST) begin
                r_x <= '0;
                r_y <= r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    // Working box starts inverted (min=all-ones, max=0) so the first red pixel sets it
    always_ff @(posedge clk) begin
        if (reset || w_enter_scan) begin
            r_wxmin <= '1;
            r_wxmax <= '0;
            r_wymin <= '1;
            r_wymax <= '0;
        end else if (r_state == ST_SCAN && w_cls == CLR_RED) begin
            if (r_x < r_wxmin) r_wxmin <= r_x;
            if (r_x > r_wxmax) r_wxmax <= r_x;
            if (r_y < r_wymin) r_wymin <= r_y;
            if (r_y > r_wymax) r_wymax <= r_y;
        end
    end

    // Box outputs follow the same publish rule as the counts
    always_ff @(posedge clk) begin
        if (reset) begin
            r_xmin <= '1;
            r_xmax <= '0;
            r_ymin <= '1;
            r_ymax <= '0;
        end else if (w_publish) begin
            r_xmin <= r_wxmin;
            r_xmax <= r_wxmax;
            r_ymin <= r_wymin;
            r_ymax <= r_wymax;
        end
    end

    assign bbox_xmin = r_xmin;
    assign bbox_xmax = r_xmax;
    assign bbox_ymin = r_ymin;
    assign bbox_ymax = r_ymax;
`endif

endmodule

// File: tb/tb_frame_scan_ctrl.sv
// tb/tb_frame_scan_ctrl.sv - scoreboard bench for frame_scan_ctrl
module tb_frame_scan_ctrl;

    localparam int W   = 160;
    localparam int H   = 120;
    localparam int N   = W * H;
    localparam int LAT = N + 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [14:0] proc_addr;
    logic [11:0] proc_data;
    logic        busy;
    logic        done;
    logic [1:0]  color;
    logic [14:0] red_cnt;
    logic [14:0] green_cnt;
    logic [14:0] blue_cnt;
`ifdef FRAME_SCAN_BBOX_EN
    logic [7:0]  bbox_xmin;
    logic [7:0]  bbox_xmax;
    logic [6:0]  bbox_ymin;
    logic [6:0]  bbox_ymax;
`endif

    always #5 clk = ~clk;

    frame_scan_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .proc_addr (proc_addr),
        .proc_data (proc_data),
        .busy      (busy),
        .done      (done),
        .color     (color),
        .red_cnt   (red_cnt),
        .green_cnt (green_cnt),
        .blue_cnt  (blue_cnt)
`ifdef FRAME_SCAN_BBOX_EN
        ,
        .bbox_xmin (bbox_xmin),
        .bbox_xmax (bbox_xmax),
        .bbox_ymin (bbox_ymin),
        .bbox_ymax (bbox_ymax)
`endif
    );

    typedef struct {
        int r;
        int g;
        int b;
        int c;
        int xmin;
        int xmax;
        int ymin;
        int ymax;
        int start_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   frame_sel = 0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Frame-buffer model with a combinational read port
    function automatic logic [11:0] pix_at(input int f, input logic [14:0] a);
        int ai;
        int x;
        int y;
        ai = int'(a);
        x  = ai % W;
        y  = ai / W;
        case (f)
            0: return 12'hF00;
            1: return 12'h777;
            2: begin
                if (ai < 300) return 12'h0F0;
                if (x >= 20 && x <= 29 && y >= 30 && y <= 39) return 12'hF00;
                return 12'h000;
            end
            3: begin
                if (ai < 600) return 12'hF00;
                if (ai < 1200) return 12'h00F;
                return 12'h000;
            end
            default: return 12'h000;
        endcase
    endfunction

    always_comb proc_data = pix_at(frame_sel, proc_addr);

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input int r, input int g, input int b, input int c,
                                input int x0, input int x1, input int y0, input int y1);
        exp_t e;
        e.r = r; e.g = g; e.b = b; e.c = c;
        e.xmin = x0; e.xmax = x1; e.ymin = y0; e.ymax = y1;
        e.start_cyc = 0;
        return e;
    endfunction

    task automatic chk_outputs(input string tag, input exp_t e);
        chk({tag, "_red_cnt"},   int'(red_cnt),   e.r);
        chk({tag, "_green_cnt"}, int'(green_cnt), e.g);
        chk({tag, "_blue_cnt"},  int'(blue_cnt),  e.b);
        chk({tag, "_color"},     int'(color),     e.c);
`ifdef FRAME_SCAN_BBOX_EN
        chk({tag, "_bbox_xmin"}, int'(bbox_xmin), e.xmin);
        chk({tag, "_bbox_xmax"}, int'(bbox_xmax), e.xmax);
        chk({tag, "_bbox_ymin"}, int'(bbox_ymin), e.ymin);
        chk({tag, "_bbox_ymax"}, int'(bbox_ymax), e.ymax);
`endif
    endtask

    // Monitor: each done pulse retires one expected scan; latency counts to the edge that first samples done
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", int'(done), 0);
            end else begin
                mon_e = sb.pop_front();
                chk("done_latency", cyc - mon_e.start_cyc + 1, LAT);
                chk("busy_in_done", int'(busy), 0);
                chk_outputs("scan", mon_e);
            end
        end
    end

    task automatic start_scan(input int f, input bit expect_done, input exp_t e);
        @(negedge clk);
        frame_sel = f;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
        chk("addr_first", int'(proc_addr), 0);
        if (expect_done) begin
            e.start_cyc = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < LAT + 20) begin
            @(negedge clk);
            t++;
        end
        chk("scoreboard_empty", sb.size(), 0);
        sb.delete();
        @(posedge clk);
        #1;
        chk("busy_after_done", int'(busy), 0);
        chk("addr_idle", int'(proc_addr), 0);
    endtask

    exp_t e_none;
    exp_t e_f0;
    exp_t e_f1;
    exp_t e_f2;
    exp_t e_f3;

    initial begin
        e_none = mk(0, 0, 0, 0, 255, 0, 127, 0);
        e_f0   = mk(N, 0, 0, 1, 0, W - 1, 0, H - 1);
        e_f1   = mk(0, 0, 0, 0, 255, 0, 127, 0);
        e_f2   = mk(100, 300, 0, 0, 20, 29, 30, 39);
        e_f3   = mk(600, 0, 600, 1, 0, W - 1, 0, 3);

        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_addr", int'(proc_addr), 0);
        chk_outputs("reset", e_none);
        @(negedge clk);
        reset = 1'b0;

        // start together with abort must not leave IDLE
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_idle", int'(busy), 0);

        // All red; a second start mid-scan must not restart it
        start_scan(0, 1'b1, e_f0);
        repeat (10) @(posedge clk);
        #1;
        chk("addr_step", int'(proc_addr), 10);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain();

        start_scan(1, 1'b1, e_f1);
        wait_drain();

        start_scan(2, 1'b1, e_f2);
        wait_drain();

        start_scan(3, 1'b1, e_f3);
        wait_drain();

        // Abort mid-scan: results from the last completed scan must stay
        start_scan(0, 1'b0, e_f0);
        repeat (4999) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_addr", int'(proc_addr), 0);
        chk("abort_done", int'(done), 0);
        repeat (20) @(posedge clk);
        #1;
        chk_outputs("abort_held", e_f3);

        // Reset mid-scan clears everything
        start_scan(0, 1'b0, e_f0);
        repeat (99) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_done", int'(done), 0);
        chk("midreset_addr", int'(proc_addr), 0);
        chk_outputs("midreset", e_none);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("post_reset_busy", int'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
